board_store: RTL and testbench

Playfield storage for the Tetris core: a 10×20 single-bit cell array that serves as the far end of `gamelogic`'s board interface.
- Answers collision reads (`board_rx/board_ry -> board_rdata`) combinationally.
- Commits lock writes (`board_we/wx/wy/wdata`) on the clock edge.
- Runs a line-clear sweep on request that removes full rows, compacts the stack and reports how many rows were removed.
- A second read-only port feeds the VGA renderer.

---
 rtl/tetris_pkg.sv | 16 +
 rtl/board_line_clear.sv | 86 ++++++++
 rtl/board_store.sv | 95 +++++++++
 tb/tb_board_store.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris playfield storage.
package tetris_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 20;
    localparam int X_W         = 4;
    localparam int Y_W         = 5;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } clr_state_e;

endpackage

// File: rtl/board_line_clear.sv
// Line-clear sweep controller: walks rows bottom-up, requests a shift-down
// whenever the examined row is full, and counts the removed rows.
module board_line_clear
    import tetris_pkg::*;
#(
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    input  logic             row_full,
    output logic             shift_en,
    output logic [Y_W-1:0]   shift_row,
    output logic             busy,
    output logic             clear_done,
    output logic [CNT_W-1:0] lines_cleared
);

    localparam logic [Y_W-1:0]   LAST_ROW = Y_W'(BOARD_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    clr_state_e       state_q, state_d;
    logic [Y_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] lines_q, lines_d;

    // Sweep state, row pointer, running count and reported result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= LAST_ROW;
            count_q <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            count_q <= count_d;
            lines_q <= lines_d;
        end
    end

    // Next-state logic; the pointer holds on a full row so the row that
    // drops into place is examined again. The result is latched on entry
    // to DONE so it changes on the same edge that raises clear_done.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        count_d  = count_q;
        lines_d  = lines_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SCAN;
                    r_d     = LAST_ROW;
                    count_d = '0;
                end
            end
            SCAN: begin
                if (row_full) begin
                    shift_en = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (r_q == '0) begin
                    state_d = DONE;
                    lines_d = count_q;
                end else begin
                    r_d = r_q - Y_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign shift_row     = r_q;
    assign busy          = (state_q != IDLE);
    assign clear_done    = (state_q == DONE);
    assign lines_cleared = lines_q;

endmodule

// File: rtl/board_store.sv
// Playfield cell array with a collision read port (walls read solid),
// a renderer read port (outside reads empty), a lock-write port and the
// line-clear compaction datapath.
module board_store
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [X_W-1:0]   board_rx,
    input  logic [Y_W-1:0]   board_ry,
    output logic             board_rdata,
    input  logic             board_we,
    input  logic [X_W-1:0]   board_wx,
    input  logic [Y_W-1:0]   board_wy,
    input  logic             board_wdata,
    input  logic             clear_req,
    output logic             busy,
    output logic             clear_done,
    output logic [CNT_W-1:0] lines_cleared,
    input  logic [X_W-1:0]   vga_rx,
    input  logic [Y_W-1:0]   vga_ry,
    output logic             vga_rdata
);

    localparam logic [X_W-1:0] X_LIM = X_W'(BOARD_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(BOARD_H);

    logic [BOARD_W-1:0] rows_q [BOARD_H];
    logic [BOARD_W-1:0] rows_d [BOARD_H];

    logic           shift_en;
    logic [Y_W-1:0] shift_row;
    logic           row_full;
    logic           board_in;
    logic           vga_in;
    logic           wr_in;

    assign board_in = (board_rx < X_LIM) && (board_ry < Y_LIM);
    assign vga_in   = (vga_rx < X_LIM) && (vga_ry < Y_LIM);
    assign wr_in    = (board_wx < X_LIM) && (board_wy < Y_LIM);
    assign row_full = (shift_row < Y_LIM) ? (&rows_q[shift_row]) : 1'b0;

    board_line_clear #(
        .BOARD_H(BOARD_H)
    ) u_line_clear (
        .clk          (CLOCK_50),
        .reset        (reset),
        .clear_req    (clear_req),
        .row_full     (row_full),
        .shift_en     (shift_en),
        .shift_row    (shift_row),
        .busy         (busy),
        .clear_done   (clear_done),
        .lines_cleared(lines_cleared)
    );

    // Next array contents: a compaction step moves rows 0..shift_row-1 down
    // by one and empties the top row; otherwise an in-range write lands only
    // while no sweep is running.
    always_comb begin
        for (int i = 0; i < BOARD_H; i++) begin
            rows_d[i] = rows_q[i];
        end
        if (shift_en) begin
            rows_d[0] = '0;
            for (int i = 1; i < BOARD_H; i++) begin
                if (Y_W'(i) <= shift_row) begin
                    rows_d[i] = rows_q[i-1];
                end
            end
        end else if (board_we && !busy && wr_in) begin
            rows_d[board_wy][board_wx] = board_wdata;
        end
    end

    // Cell array register; reset empties the whole playfield.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < BOARD_H; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BOARD_H; i++) begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    assign board_rdata = board_in ? rows_q[board_ry][board_rx] : 1'b1;
    assign vga_rdata   = vga_in   ? rows_q[vga_ry][vga_rx]     : 1'b0;

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: directed stimulus, sweep results checked by a
// scoreboard monitor that fires on clear_done.
module tb_board_store;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] board_rx;
    logic [4:0] board_ry;
    logic       board_rdata;
    logic       board_we;
    logic [3:0] board_wx;
    logic [4:0] board_wy;
    logic       board_wdata;
    logic       clear_req;
    logic       busy;
    logic       clear_done;
    logic [4:0] lines_cleared;
    logic [3:0] vga_rx;
    logic [4:0] vga_ry;
    logic       vga_rdata;

    board_store dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .board_rx     (board_rx),
        .board_ry     (board_ry),
        .board_rdata  (board_rdata),
        .board_we     (board_we),
        .board_wx     (board_wx),
        .board_wy     (board_wy),
        .board_wdata  (board_wdata),
        .clear_req    (clear_req),
        .busy         (busy),
        .clear_done   (clear_done),
        .lines_cleared(lines_cleared),
        .vga_rx       (vga_rx),
        .vga_ry       (vga_ry),
        .vga_rdata    (vga_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int lines;
        int cycles;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare each sweep result with the
    // oldest expectation when clear_done is presented.
    always @(negedge CLOCK_50) begin
        if (busy === 1'b1) busy_cnt++;
        else busy_cnt = 0;
        if (clear_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_clear_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("lines_cleared", 32'(lines_cleared), mon_e.lines);
                check("busy_cycles", busy_cnt, mon_e.cycles);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic write_cell(input int x, input int y, input logic v);
        board_we    = 1'b1;
        board_wx    = 4'(x);
        board_wy    = 5'(y);
        board_wdata = v;
        tick();
        board_we    = 1'b0;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < 10; x++) write_cell(x, y, 1'b1);
    endtask

    task automatic read_b(input int x, input int y, output logic v);
        board_rx = 4'(x);
        board_ry = 5'(y);
        #1;
        v = board_rdata;
    endtask

    task automatic read_v(input int x, input int y, output logic v);
        vga_rx = 4'(x);
        vga_ry = 5'(y);
        #1;
        v = vga_rdata;
    endtask

    task automatic count_ones(output int n);
        logic v;
        n = 0;
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 10; x++) begin
                read_b(x, y, v);
                if (v !== 1'b0) n++;
            end
        end
    endtask

    task automatic start_sweep();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("sweep_timeout_busy", 32'(busy), 0);
        tick();
        tick();
    endtask

    initial begin
        logic v;
        int   n;
        reset = 1'b1; board_rx = '0; board_ry = '0; board_we = 1'b0;
        board_wx = '0; board_wy = '0; board_wdata = 1'b0; clear_req = 1'b0;
        vga_rx = '0; vga_ry = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state and boundary reads
        check("rst_busy", 32'(busy), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_lines", 32'(lines_cleared), 0);
        count_ones(n);
        check("rst_array_ones", n, 0);
        read_b(10, 0, v);  check("wall_x10", 32'(v), 1);
        read_b(0, 20, v);  check("floor_y20", 32'(v), 1);
        read_v(10, 0, v);  check("vga_oob", 32'(v), 0);

        // Single write, out-of-range write
        write_cell(3, 19, 1'b1);
        read_b(3, 19, v);  check("wr_3_19_board", 32'(v), 1);
        read_v(3, 19, v);  check("wr_3_19_vga", 32'(v), 1);
        write_cell(12, 5, 1'b1);
        count_ones(n);
        check("oob_write_dropped", n, 1);

        // One full row with a cell above it
        fill_row(19);
        write_cell(4, 18, 1'b1);
        sb.push_back('{lines: 1, cycles: 22});
        start_sweep();
        wait_idle();
        read_b(4, 19, v);  check("drop_4_19", 32'(v), 1);
        count_ones(n);
        check("one_row_ones", n, 1);
        write_cell(4, 19, 1'b0);

        // Four full rows; blocked write and repeated request during the sweep
        for (int y = 16; y < 20; y++) fill_row(y);
        sb.push_back('{lines: 4, cycles: 25});
        start_sweep();
        tick();
        write_cell(0, 0, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle();
        read_b(0, 0, v);   check("busy_write_dropped", 32'(v), 0);
        count_ones(n);
        check("four_rows_empty", n, 0);
        tick(); tick();
        check("lines_held", 32'(lines_cleared), 4);

        // Non-adjacent full rows 17 and 19 with a partial row between them
        fill_row(17);
        fill_row(19);
        write_cell(0, 18, 1'b1);
        sb.push_back('{lines: 2, cycles: 23});
        start_sweep();
        wait_idle();
        read_b(0, 19, v);  check("gap_0_19", 32'(v), 1);
        count_ones(n);
        check("gap_ones", n, 1);
        write_cell(0, 19, 1'b0);

        // Write completing a row on the same edge as the request
        for (int x = 0; x < 9; x++) write_cell(x, 19, 1'b1);
        board_we = 1'b1; board_wx = 4'd9; board_wy = 5'd19; board_wdata = 1'b1;
        clear_req = 1'b1;
        sb.push_back('{lines: 1, cycles: 22});
        tick();
        board_we = 1'b0;
        clear_req = 1'b0;
        wait_idle();
        count_ones(n);
        check("same_cycle_write_ones", n, 0);

        // Reset in the middle of a sweep with a full row still pending
        fill_row(19);
        fill_row(5);
        start_sweep();
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_clear_done", 32'(clear_done), 0);
        check("midrst_lines", 32'(lines_cleared), 0);
        count_ones(n);
        check("midrst_array_ones", n, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
